// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for a five-stage MIPS-style pipeline.
// Holds the PC and the IF/ID register. Jumps, branches and jr/jalr resolve
// in decode and redirect the PC from there. The wrong-path instruction
// fetched in the same cycle is flushed into a bubble, so a redirect costs one
// bubble and there is no delay slot.
//
// Ports
//   clk, rst_n      clock and asynchronous active-low reset
//   Stall           hazard hold: PC and IF/ID keep their values
//   PCSrc[1:0]      decode next-PC select (00 seq/branch, 01 jump, 10 reg, 11 = 00)
//   Branch, Zero    decode beq indication and Rs==Rt result
//   RsData[31:0]    jr/jalr target
//   InstAddr[31:0]  instruction-memory address (= PC)
//   Inst[31:0]      instruction-memory read data (combinational)
//   IF_ID_*         IF/ID register outputs: instruction, PC+4 and valid
//   OpCode, Funct   fields of IF_ID_Inst for the control decoder
//   AddrErr         sticky flag: misaligned jr/jalr target loaded into the PC
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic [1:0]  PCSrc,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] RsData,
  output logic [31:0] InstAddr,
  input  logic [31:0] Inst,
  output logic [31:0] IF_ID_Inst,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic        AddrErr
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic [31:0] ifid_pcp4_q, ifid_pcp4_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] pc_plus4, jump_tgt, br_off, br_tgt, reg_tgt;
  logic        take_reg, take_jmp, take_br, redirect;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    jump_tgt = {ifid_pcp4_q[31:28], ifid_inst_q[25:0], 2'b00};
    br_off   = {{14{ifid_inst_q[15]}}, ifid_inst_q[15:0], 2'b00};
    br_tgt   = ifid_pcp4_q + br_off;
    reg_tgt  = {RsData[31:2], 2'b00};

    // A bubble in IF/ID carries no control intent, so every redirect is
    // gated by the valid bit. The reserved encoding 11 behaves like 00.
    take_reg = ifid_vld_q & (PCSrc == 2'b10);
    take_jmp = ifid_vld_q & (PCSrc == 2'b01);
    take_br  = ifid_vld_q & (PCSrc[1] ~^ PCSrc[0]) & Branch & Zero;
    redirect = take_reg | take_jmp | take_br;

    pc_d        = pc_q;
    ifid_inst_d = ifid_inst_q;
    ifid_pcp4_d = ifid_pcp4_q;
    ifid_vld_d  = ifid_vld_q;
    addr_err_d  = addr_err_q;

    if (!Stall) begin
      if (take_reg)      pc_d = reg_tgt;
      else if (take_jmp) pc_d = jump_tgt;
      else if (take_br)  pc_d = br_tgt;
      else               pc_d = pc_plus4;

      if (redirect) begin
        // Squash the fall-through fetch of this cycle.
        ifid_inst_d = 32'h0;
        ifid_pcp4_d = 32'h0;
        ifid_vld_d  = 1'b0;
      end else begin
        ifid_inst_d = Inst;
        ifid_pcp4_d = pc_plus4;
        ifid_vld_d  = 1'b1;
      end

      if (take_reg && (RsData[1:0] != 2'b00)) addr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      ifid_inst_q <= 32'h0;
      ifid_pcp4_q <= 32'h0;
      ifid_vld_q  <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      ifid_inst_q <= ifid_inst_d;
      ifid_pcp4_q <= ifid_pcp4_d;
      ifid_vld_q  <= ifid_vld_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign InstAddr      = pc_q;
  assign IF_ID_Inst    = ifid_inst_q;
  assign IF_ID_PCPlus4 = ifid_pcp4_q;
  assign IF_ID_Valid   = ifid_vld_q;
  assign OpCode        = ifid_inst_q[31:26];
  assign Funct         = ifid_inst_q[5:0];
  assign AddrErr       = addr_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall;
  logic [1:0]  PCSrc;
  logic        Branch, Zero;
  logic [31:0] RsData, Inst;
  logic [31:0] InstAddr, IF_ID_Inst, IF_ID_PCPlus4;
  logic        IF_ID_Valid, AddrErr;
  logic [5:0]  OpCode, Funct;

  // Second instance: reset PC at the top of the address space (wrap case).
  logic        w_rst_n;
  logic        w_stall, w_br, w_zero;
  logic [1:0]  w_pcsrc;
  logic [31:0] w_rs, w_inst;
  logic [31:0] w_addr, w_ifi, w_ifp;
  logic        w_vld, w_ae;
  logic [5:0]  w_op, w_fn;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0040_0000)) dut (
    .clk(clk), .rst_n(rst_n), .Stall(Stall), .PCSrc(PCSrc), .Branch(Branch),
    .Zero(Zero), .RsData(RsData), .InstAddr(InstAddr), .Inst(Inst),
    .IF_ID_Inst(IF_ID_Inst), .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid(IF_ID_Valid), .OpCode(OpCode), .Funct(Funct), .AddrErr(AddrErr)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(w_rst_n), .Stall(w_stall), .PCSrc(w_pcsrc), .Branch(w_br),
    .Zero(w_zero), .RsData(w_rs), .InstAddr(w_addr), .Inst(w_inst),
    .IF_ID_Inst(w_ifi), .IF_ID_PCPlus4(w_ifp),
    .IF_ID_Valid(w_vld), .OpCode(w_op), .Funct(w_fn), .AddrErr(w_ae)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic [31:0] ifi,
                           input logic [31:0] ifp, input logic v, input logic ae);
    chk({tag, " PC"}, InstAddr, pc);
    chk({tag, " IF_ID_Inst"}, IF_ID_Inst, ifi);
    chk({tag, " IF_ID_PCPlus4"}, IF_ID_PCPlus4, ifp);
    chk({tag, " IF_ID_Valid"}, {31'd0, IF_ID_Valid}, {31'd0, v});
    chk({tag, " AddrErr"}, {31'd0, AddrErr}, {31'd0, ae});
    chk({tag, " OpCode"}, {26'd0, OpCode}, {26'd0, ifi[31:26]});
    chk({tag, " Funct"}, {26'd0, Funct}, {26'd0, ifi[5:0]});
  endtask

  typedef struct {
    logic        stall;
    logic [1:0]  pcsrc;
    logic        br, zero;
    logic [31:0] rs, inst;
    logic [31:0] pc, ifi, ifp;
    logic        v, ae;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  initial begin
    //           stall src  br   zero rs            inst            pc             IF_ID_Inst     IF_ID_PCPlus4  v     ae
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 1'b0, 32'h0,        32'h2008_0005, 32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 1'b0, 1'b0, 32'h0,        32'h0000_0000, 32'h0040_0008, 32'h0000_0000, 32'h0040_0008, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 2'd0, 1'b0, 1'b0, 32'h0,        32'h0000_0001, 32'h0040_000C, 32'h0000_0001, 32'h0040_000C, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 1'b0, 32'h0,        32'h1109_FFFE, 32'h0040_0010, 32'h1109_FFFE, 32'h0040_0010, 1'b1, 1'b0};
    // beq taken, imm -2: target 0x400010 - 8; wrong-path fetch squashed
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h0,        32'hDEAD_BEEF, 32'h0040_0008, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    // Branch/Zero still high but IF/ID holds a bubble: ignored
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h0,        32'h2009_0007, 32'h0040_000C, 32'h2009_0007, 32'h0040_000C, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 2'd0, 1'b0, 1'b0, 32'h0,        32'h0810_0020, 32'h0040_0010, 32'h0810_0020, 32'h0040_0010, 1'b1, 1'b0};
    // jump pending under stall for two cycles
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 1'b0, 32'h0,        32'h1111_1111, 32'h0040_0010, 32'h0810_0020, 32'h0040_0010, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 2'd1, 1'b0, 1'b0, 32'h0,        32'h1111_1111, 32'h0040_0010, 32'h0810_0020, 32'h0040_0010, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 2'd1, 1'b0, 1'b0, 32'h0,        32'h1111_1111, 32'h0040_0080, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 1'b0, 32'h0,        32'h0000_0020, 32'h0040_0084, 32'h0000_0020, 32'h0040_0084, 1'b1, 1'b0};
    // jr to misaligned register target
    vecs[11] = '{1'b0, 2'd2, 1'b0, 1'b0, 32'h0040_0103, 32'h2222_2222, 32'h0040_0100, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 1'b0, 32'h0,        32'h2345_6789, 32'h0040_0104, 32'h2345_6789, 32'h0040_0104, 1'b1, 1'b1};
    // reserved 11 without branch: sequential
    vecs[13] = '{1'b0, 2'd3, 1'b0, 1'b1, 32'h0,        32'h0000_00AA, 32'h0040_0108, 32'h0000_00AA, 32'h0040_0108, 1'b1, 1'b1};
    // reserved 11 with branch taken: 0x400108 + 0xAA*4 = 0x4003B0
    vecs[14] = '{1'b0, 2'd3, 1'b1, 1'b1, 32'h0,        32'h3333_3333, 32'h0040_03B0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
    // stall while holding a bubble
    vecs[15] = '{1'b1, 2'd0, 1'b0, 1'b0, 32'h0,        32'h0000_0055, 32'h0040_03B0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
    // jr request while IF/ID is a bubble: ignored
    vecs[16] = '{1'b0, 2'd2, 1'b0, 1'b0, 32'h0000_1001, 32'h0000_0055, 32'h0040_03B4, 32'h0000_0055, 32'h0040_03B4, 1'b1, 1'b1};
    // stall overrides a valid jr
    vecs[17] = '{1'b1, 2'd2, 1'b0, 1'b0, 32'h0000_1000, 32'h4444_4444, 32'h0040_03B4, 32'h0000_0055, 32'h0040_03B4, 1'b1, 1'b1};

    rst_n = 1'b0; w_rst_n = 1'b0;
    Stall = 1'b0; PCSrc = 2'd0; Branch = 1'b0; Zero = 1'b0; RsData = 32'h0; Inst = 32'h0;
    w_stall = 1'b0; w_pcsrc = 2'd0; w_br = 1'b0; w_zero = 1'b0; w_rs = 32'h0; w_inst = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NV; i++) begin
      Stall = vecs[i].stall; PCSrc = vecs[i].pcsrc; Branch = vecs[i].br;
      Zero = vecs[i].zero; RsData = vecs[i].rs; Inst = vecs[i].inst;
      @(posedge clk);
      #1;
      chk_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ifi, vecs[i].ifp, vecs[i].v, vecs[i].ae);
      @(negedge clk);
    end

    // Asynchronous reset between edges while a jr redirect is pending.
    Stall = 1'b0; PCSrc = 2'd2; RsData = 32'h0000_2000; Inst = 32'h5555_5555;
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk_state("rst_hold", 32'h0040_0000, 32'h0, 32'h0, 1'b0, 1'b0);
    PCSrc = 2'd0; RsData = 32'h0; Inst = 32'h3C01_0040;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_state("resume", 32'h0040_0004, 32'h3C01_0040, 32'h0040_0004, 1'b1, 1'b0);

    // PC+4 wrap from the top of the address space.
    @(negedge clk);
    chk("wrap reset PC", w_addr, 32'hFFFF_FFFC);
    chk("wrap reset vld", {31'd0, w_vld}, 32'd0);
    w_inst = 32'h2010_0001;
    w_rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("wrap PC", w_addr, 32'h0000_0000);
    chk("wrap IF_ID_PCPlus4", w_ifp, 32'h0000_0000);
    chk("wrap IF_ID_Valid", {31'd0, w_vld}, 32'd1);
    chk("wrap IF_ID_Inst", w_ifi, 32'h2010_0001);
    chk("wrap AddrErr", {31'd0, w_ae}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, meaning PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port Stall  input  1  hazard hold: freeze PC and IF/ID register.
REQ-005 SHALL have port PCSrc  input  2  decode-stage next-PC select: 00 sequential/branch, 01 jump (j/jal), 10 register (jr/jalr), 11 reserved.
REQ-006 SHALL have port Branch  input  1  decode-stage beq indication.
REQ-007 SHALL have port Zero  input  1  decode-stage equality result (Rs == Rt).
REQ-008 SHALL have port RsData  input  32  jr/jalr target.
REQ-009 SHALL have port InstAddr  output  32  instruction-memory address, equal to PC.
REQ-010 SHALL have port Inst  input  32  instruction-memory read data, combinational from InstAddr.
REQ-011 SHALL have port IF_ID_Inst  output  32  registered instruction presented to decode.
REQ-012 SHALL have port IF_ID_PCPlus4  output  32  registered PC+4 of IF_ID_Inst.
REQ-013 SHALL have port IF_ID_Valid  output  1  IF_ID_Inst is a real instruction, not a bubble.
REQ-014 SHALL have ports OpCode  output  6 (IF_ID_Inst[31:26]) and Funct  output  6 (IF_ID_Inst[5:0]), feeding the control decoder.
REQ-015 SHALL have port AddrErr  output  1  sticky flag: misaligned register target seen.

Function
REQ-016 SHALL hold PC (32 bit), IF/ID instruction, IF/ID PC+4, IF/ID valid and AddrErr as state.
REQ-017 SHALL compute PCPlus4 = PC + 32'd4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-018 SHALL compute JumpTarget = {IF_ID_PCPlus4[31:28], IF_ID_Inst[25:0], 2'b00}.
REQ-019 SHALL compute BranchTarget = IF_ID_PCPlus4 + (sign-extended IF_ID_Inst[15:0] << 2), wrapping modulo 2^32.
REQ-020 SHALL compute RegTarget = {RsData[31:2], 2'b00}.
REQ-021 SHALL define Redirect = IF_ID_Valid & ((PCSrc==01) | (PCSrc==10) | (PCSrc==00 & Branch & Zero)); PCSrc==11 is treated as 00.
REQ-022 SHALL select next PC, highest priority first: Stall -> PC unchanged; PCSrc==10 -> RegTarget; PCSrc==01 -> JumpTarget; Branch&Zero -> BranchTarget; otherwise PCPlus4.
REQ-023 SHALL ignore control inputs when IF_ID_Valid=0 (next PC = PCPlus4 unless Stall).
REQ-024 SHALL, when Stall=1, hold PC, IF_ID_Inst, IF_ID_PCPlus4 and IF_ID_Valid unchanged; Stall overrides Redirect in the same cycle.
REQ-025 SHALL, when Stall=0 and Redirect=1, load IF_ID_Inst=32'h0, IF_ID_Valid=0, IF_ID_PCPlus4=32'h0 (flush of the wrong-path fetch; no delay slot).
REQ-026 SHALL, when Stall=0 and Redirect=0, load IF_ID_Inst=Inst, IF_ID_PCPlus4=PCPlus4, IF_ID_Valid=1.
REQ-027 SHALL give redirect penalty of exactly one bubble: the target instruction appears in IF/ID two edges after the redirecting instruction entered IF/ID.
REQ-028 SHALL set AddrErr=1 on any edge where PC loads RegTarget and RsData[1:0] != 2'b00; AddrErr clears only on reset.
REQ-029 SHALL drive InstAddr combinationally from PC with no additional latency.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force PC=RESET_PC, IF_ID_Inst=0, IF_ID_PCPlus4=0, IF_ID_Valid=0, AddrErr=0 (so OpCode=0, Funct=0).
REQ-031 SHALL fetch from RESET_PC on the first rising edge after rst_n deasserts; reset asserted mid-redirect or mid-stall discards all pending state.

Verification
REQ-032 SHALL cover: reset release, Stall=0, Inst=32'h2008_0005 -> after edge 1 IF_ID_Inst=32'h2008_0005, IF_ID_PCPlus4=32'h0040_0004, OpCode=6'h08, PC=32'h0040_0004.
REQ-033 SHALL cover: IF/ID holds beq with imm 16'hFFFE at PCPlus4 32'h0040_0010, Branch=1, Zero=1 -> next PC=32'h0040_0008, IF_ID_Valid=0 one cycle, then target instruction valid.
REQ-034 SHALL cover: IF/ID holds j 26'h010_0020, PCSrc=01, Stall=1 for 2 cycles then 0 -> PC, IF/ID unchanged during stall, then PC=32'h0040_0080 and bubble.
REQ-035 SHALL cover: PCSrc=10, RsData=32'h0040_0103 -> PC=32'h0040_0100, AddrErr=1 and stays 1 until rst_n=0.
REQ-036 SHALL cover: PC forced via RESET_PC=32'hFFFF_FFFC -> after one edge PC=32'h0000_0000, IF_ID_PCPlus4=32'h0000_0000, IF_ID_Valid=1.
REQ-037 SHALL cover: rst_n pulsed low asynchronously between edges during a redirect -> outputs reach reset values without a clock edge, fetch resumes at RESET_PC.
